// File: rtl/fifo_stream_pkg.sv
// -----------------------------------------------------------------------------
// fifo_stream_pkg
// Shared constants and width helpers for the FIFO stream reader and its
// output buffer. Widths are derived from the buffer depth so that any depth
// of 2 or more (not only powers of two) sizes its counters correctly.
// -----------------------------------------------------------------------------
package fifo_stream_pkg;

   localparam int DEFAULT_DATA_LEN  = 16;
   localparam int DEFAULT_BUF_DEPTH = 3;
   localparam int DEFAULT_COUNT_LEN = 32;

   // Occupancy runs 0..depth inclusive, so it needs one more code than entries.
   function automatic int occ_len(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Pointers index 0..depth-1; keep at least one bit for degenerate depths.
   function automatic int ptr_len(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   localparam int DEFAULT_OCC_LEN = occ_len(DEFAULT_BUF_DEPTH);
   localparam int DEFAULT_PTR_LEN = ptr_len(DEFAULT_BUF_DEPTH);

   // Word type at the default width; users redeclare their own data_t from
   // their DATA_LEN parameter.
   typedef logic [DEFAULT_DATA_LEN-1:0] word_t;

endpackage

// File: rtl/fifo_reader_buf.sv
// -----------------------------------------------------------------------------
// fifo_reader_buf
// Circular register buffer of DEPTH entries holding words captured from the
// FIFO until the downstream stream accepts them.
//
// Ports:
//   rclk, reset_n   clock and asynchronous active-low reset
//   push_i          write push_data_i at the write pointer this cycle
//   push_data_i     word to store
//   pop_i           retire the entry at the read pointer this cycle
//   occ_o           number of valid entries (0..DEPTH)
//   valid_o         occ_o != 0
//   data_o          entry at the read pointer (from registers, no bypass)
// -----------------------------------------------------------------------------
module fifo_reader_buf
   import fifo_stream_pkg::*;
#(
   parameter  int DATA_LEN = 16,
   parameter  int DEPTH    = 3,
   localparam int OCC_LEN  = occ_len(DEPTH),
   localparam int PTR_LEN  = ptr_len(DEPTH)
) (
   input  logic                rclk,
   input  logic                reset_n,
   input  logic                push_i,
   input  logic [DATA_LEN-1:0] push_data_i,
   input  logic                pop_i,
   output logic [OCC_LEN-1:0]  occ_o,
   output logic                valid_o,
   output logic [DATA_LEN-1:0] data_o
);

   typedef logic [DATA_LEN-1:0] data_t;

   data_t              mem_q [DEPTH];
   logic [DEPTH-1:0]   wr_sel;
   logic [PTR_LEN-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_LEN-1:0] rd_ptr_q, rd_ptr_d;
   logic [OCC_LEN-1:0] occ_q, occ_d;

   // Explicit wrap so non power-of-two depths never visit unused codes.
   function automatic logic [PTR_LEN-1:0] ptr_inc(input logic [PTR_LEN-1:0] p);
      return (p == PTR_LEN'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // One-hot write select per entry.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
      assign wr_sel[gi] = push_i && (wr_ptr_q == PTR_LEN'(gi));
   end

   always_comb begin
      wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      occ_d    = occ_q;
      case ({push_i, pop_i})
         2'b10:   occ_d = occ_q + 1'b1;
         2'b01:   occ_d = occ_q - 1'b1;
         default: occ_d = occ_q;   // push+pop together: both pointers move, occ holds
      endcase
   end

   always_ff @(posedge rclk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Entries are reset so data_o reads zero out of reset (rd_ptr is 0).
   // A pop and push on the same entry is safe: data_o reads the old value
   // this cycle and the new value lands on the edge.
   always_ff @(posedge rclk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) mem_q[i] <= push_data_i;
         end
      end
   end

   assign occ_o   = occ_q;
   assign valid_o = (occ_q != '0);
   assign data_o  = mem_q[rd_ptr_q];

   // Credit logic upstream must never push into a full buffer.
   assert property (@(posedge rclk) disable iff (!reset_n)
                    !(push_i && !pop_i && (occ_q == OCC_LEN'(DEPTH))));

endmodule

// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
// Read-side consumer for a dual-clock FIFO without show-ahead. Issues read
// requests against a credit limit, captures the word returned one cycle later
// into a small buffer, and presents it as a valid/ready stream.
//
// Ports:
//   rclk, reset_n    read clock and asynchronous active-low reset
//   fifo_data_out    FIFO q, valid the cycle after fifo_rd_en
//   fifo_rd_empty    FIFO read-side empty flag
//   fifo_rd_en       FIFO read request (never depends on m_ready)
//   m_data, m_valid  stream output
//   m_ready          downstream ready
//   word_count       completed handshakes since reset, wraps at 2^COUNT_LEN
// -----------------------------------------------------------------------------
module fifo_stream_reader
   import fifo_stream_pkg::*;
#(
   parameter int DATA_LEN  = 16,
   parameter int BUF_DEPTH = 3,
   parameter int COUNT_LEN = 32
) (
   input  logic                 rclk,
   input  logic                 reset_n,
   input  logic [DATA_LEN-1:0]  fifo_data_out,
   input  logic                 fifo_rd_empty,
   output logic                 fifo_rd_en,
   output logic [DATA_LEN-1:0]  m_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [COUNT_LEN-1:0] word_count
);

   localparam int OCC_LEN = occ_len(BUF_DEPTH);

   logic                 pend_q, pend_d;
   logic [OCC_LEN-1:0]   occ;
   logic [OCC_LEN:0]     credit_used;
   logic                 pop;
   logic [COUNT_LEN-1:0] word_count_q, word_count_d;

   // Buffered words plus the one in flight from the FIFO. Counting the
   // in-flight word guarantees a slot exists when it returns, so nothing
   // is ever dropped and m_ready stays out of the read-enable path.
   assign credit_used = {1'b0, occ} + {{OCC_LEN{1'b0}}, pend_q};

   // reset_n is included so the request drops the moment reset asserts.
   assign fifo_rd_en = reset_n & ~fifo_rd_empty &
                       (credit_used < (OCC_LEN + 1)'(BUF_DEPTH));

   assign pop = m_valid & m_ready;

   always_comb begin
      pend_d       = fifo_rd_en;
      word_count_d = word_count_q + COUNT_LEN'(pop);
   end

   always_ff @(posedge rclk or negedge reset_n) begin
      if (!reset_n) begin
         pend_q       <= 1'b0;
         word_count_q <= '0;
      end else begin
         pend_q       <= pend_d;
         word_count_q <= word_count_d;
      end
   end

   fifo_reader_buf #(
      .DATA_LEN (DATA_LEN),
      .DEPTH    (BUF_DEPTH)
   ) u_buf (
      .rclk        (rclk),
      .reset_n     (reset_n),
      .push_i      (pend_q),
      .push_data_i (fifo_data_out),
      .pop_i       (pop),
      .occ_o       (occ),
      .valid_o     (m_valid),
      .data_o      (m_data)
   );

   assign word_count = word_count_q;

   assert property (@(posedge rclk) disable iff (!reset_n)
                    credit_used <= (OCC_LEN + 1)'(BUF_DEPTH));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_stream_reader
// Drives the reader from a behavioural show-ahead-off FIFO model and checks
// the stream against a scoreboard of words read, plus the read-issue and
// latency rules expressed in terms of words outstanding.
// -----------------------------------------------------------------------------
module tb_fifo_stream_reader;

   localparam int DATA_LEN  = 16;
   localparam int BUF_DEPTH = 3;
   localparam int COUNT_LEN = 32;

   logic                 rclk = 1'b0;
   logic                 reset_n = 1'b0;
   logic [DATA_LEN-1:0]  fifo_data_out = '0;
   logic                 fifo_rd_empty = 1'b1;
   logic                 m_ready = 1'b0;
   logic                 fifo_rd_en;
   logic [DATA_LEN-1:0]  m_data;
   logic                 m_valid;
   logic [COUNT_LEN-1:0] word_count;

   // Narrow-counter twin driven by the same inputs.
   logic                 rd_en4;
   logic [DATA_LEN-1:0]  m_data4;
   logic                 m_valid4;
   logic [3:0]           word_count4;

   always #5 rclk = ~rclk;

   fifo_stream_reader #(.DATA_LEN(DATA_LEN), .BUF_DEPTH(BUF_DEPTH), .COUNT_LEN(COUNT_LEN)) dut (
      .rclk(rclk), .reset_n(reset_n), .fifo_data_out(fifo_data_out),
      .fifo_rd_empty(fifo_rd_empty), .fifo_rd_en(fifo_rd_en), .m_data(m_data),
      .m_valid(m_valid), .m_ready(m_ready), .word_count(word_count));

   fifo_stream_reader #(.DATA_LEN(DATA_LEN), .BUF_DEPTH(BUF_DEPTH), .COUNT_LEN(4)) dut4 (
      .rclk(rclk), .reset_n(reset_n), .fifo_data_out(fifo_data_out),
      .fifo_rd_empty(fifo_rd_empty), .fifo_rd_en(rd_en4), .m_data(m_data4),
      .m_valid(m_valid4), .m_ready(m_ready), .word_count(word_count4));

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Model state
   logic [DATA_LEN-1:0] src_q[$];    // words still inside the FIFO
   logic [DATA_LEN-1:0] exp_q[$];    // words read but not yet delivered, in order
   int                  stamp_q[$];  // cycle each of those was read
   int  cyc = 0;
   int  pops = 0;                    // handshakes since last reset
   int  ready_mode = 0;              // 0 low, 1 high, 2 random
   bit  toggle_empty = 0;
   bit  force_empty = 0;
   int  rd_n, pop_n, first_rd, last_rd, first_pop, last_pop;

   task automatic clear_stats();
      rd_n = 0; pop_n = 0; first_rd = -1; last_rd = -1; first_pop = -1; last_pop = -1;
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic run_cycle();
      bit                  rd;
      bit                  pop;
      logic [DATA_LEN-1:0] w;
      w = '0;
      check("rd_en", fifo_rd_en,
            reset_n && !fifo_rd_empty && (exp_q.size() < BUF_DEPTH));
      check("m_valid", m_valid, (exp_q.size() > 0) && (stamp_q[0] <= cyc - 2));
      check("word_count", word_count, 64'(pops));
      check("word_count4", word_count4, 64'(pops % 16));
      check("twin", {rd_en4, m_valid4, m_data4}, {fifo_rd_en, m_valid, m_data});
      check("rd_while_empty", fifo_rd_en && fifo_rd_empty, 0);
      check("credit", exp_q.size() + int'(fifo_rd_en) <= BUF_DEPTH, 1);
      pop = m_valid && m_ready;
      rd  = fifo_rd_en;
      if (pop) begin
         if (exp_q.size() == 0) begin
            check("pop_without_word", exp_q.size(), 1);
         end else begin
            check("m_data", m_data, exp_q[0]);
            void'(exp_q.pop_front());
            void'(stamp_q.pop_front());
         end
         pops++; pop_n++;
         if (first_pop < 0) first_pop = cyc;
         last_pop = cyc;
         $display("xfer %0d data=%04h cyc=%0d", pops, m_data, cyc);
      end
      if (rd) begin
         w = (src_q.size() > 0) ? src_q.pop_front() : 16'hDEAD;
         exp_q.push_back(w);
         stamp_q.push_back(cyc);
         rd_n++;
         if (first_rd < 0) first_rd = cyc;
         last_rd = cyc;
      end
      @(posedge rclk);
      #1;
      // Show-ahead off: q is valid the cycle after the request.
      fifo_data_out = rd ? w : DATA_LEN'($urandom);
      cyc++;
      force_empty   = toggle_empty ? ~force_empty : 1'b0;
      fifo_rd_empty = (src_q.size() == 0) || force_empty;
      m_ready       = (ready_mode == 1) ? 1'b1 :
                      (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge rclk);
   endtask

   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) run_cycle();
   endtask

   task automatic drain(input string tag, input int budget);
      int n;
      n = 0;
      while ((src_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
         run_cycle();
         n++;
      end
      check(tag, n < budget, 1);
   endtask

   task automatic load(input int count, input bit counting);
      for (int i = 0; i < count; i++)
         src_q.push_back(counting ? DATA_LEN'(i + 1) : DATA_LEN'($urandom));
      fifo_rd_empty = (src_q.size() == 0) || force_empty;
      #1;
   endtask

   initial begin
      logic [DATA_LEN-1:0] t2_first;

      // Reset state
      @(negedge rclk);
      #1;
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_rd_en", fifo_rd_en, 0);
      check("rst_word_count", word_count, 0);

      // 1: four counting words, ready high, from reset release
      clear_stats();
      ready_mode = 1; m_ready = 1'b1;
      load(4, 1'b1);
      check("rst_rd_en_held", fifo_rd_en, 0);
      reset_n = 1'b1;
      #1;
      run_n(8);
      check("t1_reads", rd_n, 4);
      check("t1_rd_consecutive", last_rd - first_rd, 3);
      check("t1_first_latency", first_pop - first_rd, 2);
      check("t1_pop_consecutive", last_pop - first_pop, 3);
      check("t1_word_count", word_count, 4);

      // 2: backpressure with eight words waiting
      clear_stats();
      ready_mode = 0; m_ready = 1'b0;
      load(8, 1'b0);
      t2_first = src_q[0];
      run_n(10);
      check("t2_reads_stalled", rd_n, BUF_DEPTH);
      check("t2_rd_en_low", fifo_rd_en, 0);
      check("t2_hold_valid", m_valid, 1);
      check("t2_hold_data", m_data, t2_first);
      ready_mode = 1; m_ready = 1'b1;
      drain("t2_drain", 60);
      check("t2_pops", pop_n, 8);

      // 3: empty flag toggling, random ready
      clear_stats();
      toggle_empty = 1'b1; ready_mode = 2;
      load(40, 1'b0);
      drain("t3_drain", 600);
      check("t3_pops", pop_n, 40);
      toggle_empty = 1'b0; force_empty = 1'b0;

      // 4: steady push+pop at occupancy one across pointer wrap
      clear_stats();
      ready_mode = 1; m_ready = 1'b1;
      load(15, 1'b0);
      drain("t4_drain", 60);
      check("t4_pops", pop_n, 15);
      check("t4_throughput", last_pop - first_pop, 14);

      // 5: reset with one word in flight and two buffered
      clear_stats();
      ready_mode = 1; m_ready = 1'b1;
      load(10, 1'b0);
      run_n(5);
      ready_mode = 0; m_ready = 1'b0;
      run_n(1);
      check("t5_outstanding", exp_q.size(), 3);
      check("t5_pre_count", word_count, pops);
      reset_n = 1'b0;
      #1;
      check("t5_async_valid", m_valid, 0);
      check("t5_async_rd_en", fifo_rd_en, 0);
      check("t5_async_count", word_count, 0);
      check("t5_async_data", m_data, 0);
      exp_q.delete(); stamp_q.delete(); src_q.delete();
      pops = 0;
      run_n(2);

      // 6: seventeen words after reset; 4-bit counter wraps to 1
      clear_stats();
      ready_mode = 2;
      load(17, 1'b0);
      reset_n = 1'b1;
      #1;
      drain("t6_drain", 300);
      check("t6_pops", pop_n, 17);
      check("t6_word_count", word_count, 17);
      check("t6_word_count4", word_count4, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
